// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave bridging the bus to a simple dual-port block RAM with a registered read port.
// Zero-wait reads/writes with byte lanes, read-after-write forwarding and a two-cycle ERROR response.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_mask;
  logic                  r_wr;
  logic                  r_rd;
  logic                  r_fwd_hit;
  logic [3:0]            r_fwd_mask;
  logic [31:0]           r_fwd_data;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_legal;
  logic                  w_wr_active;
  logic                  w_fwd_hit;
  logic [3:0]            w_mask;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [31:0]           w_merged;
  logic                  w_unused;

  assign w_unused = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign w_word    = HADDR[ADDR_WIDTH+1:2];
  assign w_accept  = HSEL & HTRANS[1] & HREADY;
  assign w_illegal = (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign w_legal   = w_accept & ~w_illegal;

  always_comb begin
    w_mask = 4'b1111;
    case (HSIZE)
      3'd0:    w_mask = 4'b0001 << HADDR[1:0];
      3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // A stalled bus never writes; the write lands on the edge that completes the data phase.
  assign w_wr_active = r_wr & HREADY;
  assign w_fwd_hit   = w_wr_active & w_legal & ~HWRITE & (w_word == r_addr);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= '0;
      r_mask <= '0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
    end else if (w_legal) begin
      r_addr <= w_word;
      r_mask <= w_mask;
      r_wr   <= HWRITE;
      r_rd   <= ~HWRITE;
    end else if (HREADY) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
    end
  end

  // The RAM is read-first on a collision, so the bytes being written this cycle are captured here.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else if (w_fwd_hit) begin
      r_fwd_hit  <= 1'b1;
      r_fwd_mask <= r_mask;
      r_fwd_data <= HWDATA;
    end else if (HREADY) begin
      r_fwd_hit  <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept & w_illegal) w_state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP       = 1'b1;
        w_state_nxt = (w_accept & w_illegal) ? ST_ERR1 : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_merged = ram_doutb;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_fwd_hit && r_fwd_mask[i]) w_merged[8*i +: 8] = r_fwd_data[8*i +: 8];
    end
  end

  assign HRDATA    = r_rd ? w_merged : 32'h0;
  assign ram_addra = r_addr;
  assign ram_dina  = HWDATA;
  assign ram_wea   = w_wr_active ? r_mask : 4'b0000;
  assign ram_addrb = w_word;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: directed test-plan sequence with literal expectations, then randomized
// traffic checked every cycle against a transaction-level memory model.
module tb_ahb_bram_ctrl;

  localparam int AW = 14;
  localparam int NW = 1 << AW;

  logic          HCLK    = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL    = 1'b0;
  logic [31:0]   HADDR   = '0;
  logic [1:0]    HTRANS  = '0;
  logic [2:0]    HSIZE   = '0;
  logic          HWRITE  = 1'b0;
  logic [31:0]   HWDATA  = '0;
  logic          stall_n = 1'b1;
  logic          hready;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [3:0]    ram_wea;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_doutb = '0;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram  [NW];
  logic [31:0] gmem [NW];

  bit          m_valid = 1'b0;
  bit          m_write = 1'b0;
  logic [AW-1:0] m_word = '0;
  logic [3:0]  m_mask = '0;
  int          m_err  = 0;

  assign hready = HREADYOUT & stall_n;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (hready),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_wea   (ram_wea),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  always #5 HCLK = ~HCLK;

  // Block RAM: byte-enabled write port, registered read port returning old data on collision.
  always @(posedge HCLK) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wea[b]) ram[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    ram_doutb <= ram[ram_addrb];
  end

  function automatic logic [31:0] init_word(int i);
    return {16'hC0DE, i[15:0]};
  endfunction

  function automatic bit f_illegal(logic [2:0] sz, logic [1:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a != 2'b00);
  endfunction

  function automatic logic [3:0] f_mask(logic [2:0] sz, logic [1:0] a);
    case (sz)
      3'd0:    return 4'(1 << a);
      3'd1:    return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory updated once per completed write, read returns the whole current word.
  always @(negedge HCLK) begin : p_cmp
    logic       hb;
    logic       acc;
    logic [3:0] ew;
    logic [31:0] erd;
    if (!HRESETn) begin
      chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_wea", 32'(ram_wea), 32'd0);
      chk("rst_hrdata", HRDATA, 32'h0);
      m_valid = 1'b0;
      m_err   = 0;
    end else begin
      hb = (m_err != 1) && stall_n;
      chk("hreadyout", 32'(HREADYOUT), (m_err != 1) ? 32'd1 : 32'd0);
      chk("hresp", 32'(HRESP), (m_err != 0) ? 32'd1 : 32'd0);
      chk("addrb", 32'(ram_addrb), 32'(HADDR[AW+1:2]));
      ew = (m_valid && m_write && hb) ? m_mask : 4'h0;
      chk("wea", 32'(ram_wea), 32'(ew));
      if (ew != 4'h0) begin
        chk("addra", 32'(ram_addra), 32'(m_word));
        chk("dina", ram_dina, HWDATA);
      end
      erd = (m_valid && !m_write) ? gmem[m_word] : 32'h0;
      chk("hrdata", HRDATA, erd);

      if (ew != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (ew[b]) gmem[m_word][8*b +: 8] = HWDATA[8*b +: 8];
        end
      end
      acc = HSEL && HTRANS[1] && hb;
      if (acc && f_illegal(HSIZE, HADDR[1:0])) begin
        m_err   = 1;
        m_valid = 1'b0;
      end else begin
        m_err = (m_err == 1) ? 2 : 0;
        if (acc) begin
          m_valid = 1'b1;
          m_write = HWRITE;
          m_word  = HADDR[AW+1:2];
          m_mask  = f_mask(HSIZE, HADDR[1:0]);
        end else if (hb) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                     input logic [2:0] sz, input bit wr, input logic [31:0] wd);
    @(posedge HCLK);
    #1;
    HSEL   = sel;
    HTRANS = tr;
    HADDR  = a;
    HSIZE  = sz;
    HWRITE = wr;
    HWDATA = wd;
  endtask

  initial begin
    logic [31:0] r;
    int unsigned w;
    int unsigned off;
    for (int i = 0; i < NW; i++) begin
      ram[i]  = init_word(i);
      gmem[i] = init_word(i);
    end

    repeat (3) @(posedge HCLK);
    #1;
    chk("lit_rst_ready", 32'(HREADYOUT), 32'd1);
    chk("lit_rst_resp", 32'(HRESP), 32'd0);
    chk("lit_rst_wea", 32'(ram_wea), 32'd0);
    HRESETn = 1'b1;

    cyc(1, 2'b10, 32'h0, 3'd2, 0, 32'h0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    #2 chk("lit_init_read", HRDATA, 32'hC0DE0000);

    cyc(1, 2'b10, 32'h100, 3'd2, 1, 32'h0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'hDEADBEEF);
    #2;
    chk("lit_word_wea", 32'(ram_wea), 32'hF);
    chk("lit_word_addra", 32'(ram_addra), 32'h40);
    cyc(1, 2'b10, 32'h100, 3'd2, 0, 32'h0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    #2 chk("lit_word_read", HRDATA, 32'hDEADBEEF);

    cyc(1, 2'b10, 32'h203, 3'd0, 1, 32'h0);
    cyc(1, 2'b11, 32'h200, 3'd1, 1, 32'h11000000);
    #2 chk("lit_byte_wea", 32'(ram_wea), 32'h8);
    cyc(1, 2'b10, 32'h200, 3'd2, 0, 32'h00002233);
    #2 chk("lit_half_wea", 32'(ram_wea), 32'h3);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    #2 chk("lit_lanes_read", HRDATA, 32'h11DE2233);

    cyc(1, 2'b10, 32'h0, 3'd2, 1, 32'h0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'hAAAAAAAA);
    cyc(1, 2'b10, 32'h1, 3'd0, 1, 32'h0);
    cyc(1, 2'b10, 32'h0, 3'd2, 0, 32'h00005500);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    #2 chk("lit_fwd_read", HRDATA, 32'hAAAA55AA);

    cyc(1, 2'b10, 32'h102, 3'd2, 1, 32'h0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h12345678);
    #2;
    chk("lit_err1_ready", 32'(HREADYOUT), 32'd0);
    chk("lit_err1_resp", 32'(HRESP), 32'd1);
    chk("lit_err1_wea", 32'(ram_wea), 32'd0);
    cyc(1, 2'b10, 32'h100, 3'd2, 0, 32'h0);
    #2;
    chk("lit_err2_ready", 32'(HREADYOUT), 32'd1);
    chk("lit_err2_resp", 32'(HRESP), 32'd1);
    chk("lit_err2_wea", 32'(ram_wea), 32'd0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    #2;
    chk("lit_err_unchanged", HRDATA, 32'hDEADBEEF);
    chk("lit_err_done", 32'(HRESP), 32'd0);

    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK);
      #1;
      stall_n = 1'b0;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h300; HSIZE = 3'd2; HWRITE = 1'b1;
      HWDATA = 32'hBADBAD00;
      #2 chk("lit_stall_wea", 32'(ram_wea), 32'd0);
    end
    @(posedge HCLK);
    #1;
    stall_n = 1'b1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hBADBAD01;
    #2 chk("lit_after_stall_wea", 32'(ram_wea), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      @(posedge HCLK);
      #1;
      if ($urandom_range(0, 599) == 0) begin
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
      end
      stall_n = (!m_valid && m_err == 0 && $urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
      r   = $urandom;
      w   = ($urandom_range(0, 15) == 0) ? $urandom_range(0, NW - 1) : $urandom_range(0, 7);
      off = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 3);
      HSEL   = ($urandom_range(0, 9) < 8);
      HTRANS = 2'($urandom);
      HWRITE = 1'($urandom);
      HSIZE  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      HADDR  = (r & 32'hFFFF0000) | (w << 2) | off;
      HWDATA = $urandom;
    end

    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    cyc(0, 2'b00, 32'h0, 3'd0, 0, 32'h0);
    @(negedge HCLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
